// File: rtl/button_press_classifier_if.sv
// Gesture-classifier bus: debounced button level in, gesture pulses and
// status levels out. The master side drives the button level; the
// classifier is the slave.
interface button_press_classifier_if;
    logic debounced;
    logic single_press;
    logic double_press;
    logic long_press;
    logic held;
    logic busy;

    modport master (
        output debounced,
        input  single_press,
        input  double_press,
        input  long_press,
        input  held,
        input  busy
    );

    modport slave (
        input  debounced,
        output single_press,
        output double_press,
        output long_press,
        output held,
        output busy
    );
endinterface

// File: rtl/button_press_classifier.sv
// Classifies a debounced button level into single, double and long press
// events. Each event is a one-cycle registered pulse. Time is counted in
// prescaled ticks of TICK_DIV clock cycles.
module button_press_classifier #(
    parameter int TICK_DIV = 100_000,
    parameter int LONG_MS  = 1000,
    parameter int GAP_MS   = 250
) (
    input  logic                        clk,
    input  logic                        reset,
    button_press_classifier_if.slave    bus
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_MS  = (LONG_MS > GAP_MS) ? LONG_MS : GAP_MS;
    localparam int MS_W    = $clog2(MAX_MS + 1);

    // Expiry of limit L falls on the edge where the prescaler is about to
    // wrap while the ms counter still reads L-1, i.e. edge L*TICK_DIV.
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]    LONG_LAST  = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0]    GAP_LAST   = MS_W'(GAP_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT_GAP,
        PRESS2,
        LONG_HOLD
    } state_t;

    state_t               state;
    logic                 btn_q;
    logic [PRESC_W-1:0]   presc;
    logic [MS_W-1:0]      ms_cnt;
    logic                 single_q;
    logic                 double_q;
    logic                 long_q;
    logic                 held_q;
    logic                 busy_q;

    logic rise;
    logic fall;
    logic tick_wrap;
    logic long_expired;
    logic gap_expired;

    assign rise         = bus.debounced & ~btn_q;
    assign fall         = ~bus.debounced & btn_q;
    assign tick_wrap    = (presc == PRESC_LAST);
    assign long_expired = tick_wrap && (ms_cnt == LONG_LAST);
    assign gap_expired  = tick_wrap && (ms_cnt == GAP_LAST);

    assign bus.single_press = single_q;
    assign bus.double_press = double_q;
    assign bus.long_press   = long_q;
    assign bus.held         = held_q;
    assign bus.busy         = busy_q;

    // Edge register, timer and gesture FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            // NOTE: btn_q loads the live level rather than 0 so a button
            // already held at reset release does not look like a fresh rise.
            btn_q    <= bus.debounced;
            presc    <= '0;
            ms_cnt   <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            btn_q    <= bus.debounced;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;

            // NOTE: non-blocking assignments make the later clear on a state
            // transition override this advance within the same edge.
            if (state == PRESS1 || state == WAIT_GAP) begin
                if (tick_wrap) begin
                    presc  <= '0;
                    ms_cnt <= ms_cnt + MS_W'(1);
                end else begin
                    presc  <= presc + PRESC_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state  <= PRESS1;
                        busy_q <= 1'b1;
                        presc  <= '0;
                        ms_cnt <= '0;
                    end
                end
                PRESS1: begin
                    // Expiry wins over a release on the same edge.
                    if (long_expired) begin
                        state  <= LONG_HOLD;
                        long_q <= 1'b1;
                        held_q <= 1'b1;
                        presc  <= '0;
                        ms_cnt <= '0;
                    end else if (fall) begin
                        state  <= WAIT_GAP;
                        presc  <= '0;
                        ms_cnt <= '0;
                    end
                end
                WAIT_GAP: begin
                    // A second press wins over gap expiry on the same edge.
                    if (rise) begin
                        state  <= PRESS2;
                        presc  <= '0;
                        ms_cnt <= '0;
                    end else if (gap_expired) begin
                        state    <= IDLE;
                        single_q <= 1'b1;
                        busy_q   <= 1'b0;
                        presc    <= '0;
                        ms_cnt   <= '0;
                    end
                end
                PRESS2: begin
                    if (fall) begin
                        state    <= IDLE;
                        double_q <= 1'b1;
                        busy_q   <= 1'b0;
                    end
                end
                LONG_HOLD: begin
                    if (fall) begin
                        state  <= IDLE;
                        held_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    held_q <= 1'b0;
                    busy_q <= 1'b0;
                    presc  <= '0;
                    ms_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Classifies the clean, single-clock-domain `debounced` level from the button debouncer into gesture events: single press, double press and long press. Each event is a one-cycle pulse. The block sits directly downstream of the debouncer and feeds the application control logic. Time is measured with an internal prescaled millisecond tick, so thresholds are set in milliseconds.

## Interface
- `TICK_DIV`, default 100_000: clock cycles per timer tick (1 ms at 100 MHz); must be ≥ 1.
- `LONG_MS`, default 1000: ticks a first press must be held to count as a long press; must be ≥ 1.
- `GAP_MS`, default 250: maximum ticks from first release to second press for a double press; must be ≥ 1.

Ports:
- `clk` in 1: single clock for everything.
- `reset` in 1: synchronous, active-high reset.
- `debounced` in 1: debounced button level from the debouncer, already synchronous to `clk`; 1 = pressed.
- `single_press` out 1: one-cycle pulse marking a single short press.
- `double_press` out 1: one-cycle pulse marking a double press.
- `long_press` out 1: one-cycle pulse marking a long press.
- `held` out 1: level, high while in LONG_HOLD.
- `busy` out 1: level, high whenever the state is not IDLE.

## Operation
- Input edge detection:
  - `btn_q` registers `debounced` every cycle.
  - `rise = debounced & ~btn_q`; `fall = ~debounced & btn_q`.
- Timer:
  - Prescaler counts 0..TICK_DIV-1; ms counter increments on prescaler wrap.
  - Both counters clear on every state transition.
  - Expiry for limit L is the L·TICK_DIV-th edge after the entry edge (entry edge = 0).
  - Widths: prescaler `$clog2(TICK_DIV)` (minimum 1); ms counter `$clog2(max(LONG_MS,GAP_MS)+1)`.
  - The ms counter never wraps; it only runs inside timed states.
- FSM:
  - IDLE: on `rise` → PRESS1.
  - PRESS1:
    - On LONG_MS expiry → LONG_HOLD, and emit `long_press`.
    - Else on `fall` → WAIT_GAP.
    - Expiry takes priority over a simultaneous `fall`.
  - WAIT_GAP:
    - On `rise` → PRESS2.
    - Else on GAP_MS expiry → IDLE, and emit `single_press`.
    - `rise` takes priority over a simultaneous expiry.
  - PRESS2: untimed; on `fall` → IDLE, and emit `double_press`. A long hold of the second press is still a double press.
  - LONG_HOLD: on `fall` → IDLE; no event is emitted.
- Exactly one event is emitted per gesture; at most one pulse output is high in any cycle.
- Reset, synchronous:
  - State → IDLE; counters → 0; all outputs → 0.
  - `btn_q` loads `debounced` rather than 0, so a press already held at reset release produces no `rise`. The block waits for release and a fresh press.
  - Reset mid-gesture discards the gesture silently.

## Timing
- Reset values: `single_press`, `double_press`, `long_press`, `held` and `busy` are all 0.
- All outputs are registered.
  - Pulses are high for exactly the one cycle after the clock edge on which the triggering transition occurs.
  - `held` and `busy` follow the state register with the same one-cycle delay.
- Latency, measured from the edge where `debounced` is first sampled high (the `rise` edge, entry to PRESS1):
  - `long_press` is high in the cycle after edge LONG_MS·TICK_DIV.
- Latency, measured from the `fall` edge of the first release:
  - `single_press` is high in the cycle after edge GAP_MS·TICK_DIV.
- `double_press` is high in the cycle after the second `fall` edge.
- Minimum first press is 1 cycle; pulses of any length are classified.

## Test plan
Bench parameters: TICK_DIV=4, LONG_MS=10, GAP_MS=5, giving long = 40 cycles and gap = 20 cycles.

1. **Single press.** Reset 3 cycles, hold `debounced`=1 for 10 cycles, then 0 → `single_press` high for 1 cycle, 21 cycles after the release edge. No other pulses; `busy` falls with it.
2. **Double press.** Press 10 cycles, release 8, press 10, release → `double_press` for 1 cycle, 1 cycle after the second release. No `single_press`.
3. **Long press.** Hold 60 cycles → `long_press` 1 cycle at press edge + 41. `held` high from then until 1 cycle after release. No event on release.
4. **Boundaries.** Release on exactly the 40th edge → `long_press`, not WAIT_GAP. Second press rising on exactly the 20th gap edge → `double_press`, not `single_press`.
5. **Reset.** Assert `reset` during WAIT_GAP → no `single_press` afterwards. Hold the button across reset deassertion → no event until release plus a fresh press.
6. **Long second press.** Hold the second press of a double for 100 cycles → only `double_press`, on release; no `long_press`. Follow with back-to-back gestures → each classified independently.
